// File: rtl/uart_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_ctrl_pkg
// Description : Shared UART control definitions. Holds the receiver/transmitter
//               state encoding, the default clock and baud constants, and a
//               helper for the per-bit clock count.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package uart_ctrl_pkg;

   localparam int unsigned c_DEFAULT_CLK_FREQ = 100_000_000;
   localparam int unsigned c_DEFAULT_BAUD     = 115200;

   // Explicit 2-bit encoding so the state register width is fixed
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_e;

   // Clocks per serial bit, integer-truncated
   function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                input int unsigned baud);
      return clk_freq / baud;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock register-based FIFO. Head is read combinationally
//               and forced to zero while empty. A push that finds the FIFO full
//               with no simultaneous pop is dropped and sets a sticky flag.
// Ports       : clk, rst        - clock, async active-high reset
//               push_i, wdata_i - write request and data
//               pop_i           - read request (ignored while empty)
//               rdata_o         - head entry, 0 when empty
//               empty_o         - FIFO holds no entries
//               overflow_o      - sticky, a push was dropped
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             empty_o,
   output logic             overflow_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             overflow_q;

   logic w_full;
   logic w_empty;
   logic w_pop;
   logic w_push;
   logic w_drop;

   assign w_full  = (count_q == (AW + 1)'(DEPTH));
   assign w_empty = (count_q == '0);
   assign w_pop   = pop_i && !w_empty;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept
   assign w_push  = push_i && (!w_full || w_pop);
   assign w_drop  = push_i && w_full && !w_pop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (w_push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (w_pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         if (w_push && !w_pop) begin
            count_q <= count_q + (AW + 1)'(1);
         end else if (w_pop && !w_push) begin
            count_q <= count_q - (AW + 1)'(1);
         end
         if (w_drop) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // Storage needs no reset: every read is gated by the empty flag
   always_ff @(posedge clk) begin
      if (w_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   assign rdata_o    = w_empty ? '0 : mem_q[rd_ptr_q];
   assign empty_o    = w_empty;
   assign overflow_o = overflow_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : 8N1 UART receiver with a receive FIFO. The serial line is
//               double-synchronised, the start bit is re-checked at mid-bit,
//               data bits are sampled once per bit period, and bytes with a
//               valid stop bit are pushed into the FIFO.
// Ports       : clk, rst   - clock, async active-high reset
//               rx         - asynchronous serial input, idle high
//               r_enable   - one-cycle pop request from the consumer
//               r_ready    - FIFO non-empty
//               r_data     - FIFO head byte, 0 when empty
//               overflow   - sticky, a received byte was dropped
//               frame_err  - one-cycle pulse, stop bit sampled low
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
   import uart_ctrl_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = c_DEFAULT_CLK_FREQ,
   parameter int unsigned BAUD       = c_DEFAULT_BAUD,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic       r_enable,
   output logic       r_ready,
   output logic [7:0] r_data,
   output logic       overflow,
   output logic       frame_err
);

   localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
   localparam int unsigned HALF         = CLKS_PER_BIT / 2;
   localparam int unsigned CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] c_CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] c_CNT_HALF = CW'((HALF > 0) ? HALF - 1 : 0);

   // Synchroniser flops reset to the idle line level
   logic rx_meta_q;
   logic rx_s_q;

   uart_state_e state_q;
   uart_state_e state_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic [2:0]    idx_q;
   logic [2:0]    idx_d;
   logic [7:0]    shift_q;
   logic [7:0]    shift_d;

   logic w_push;
   logic w_frame_err;
   logic w_empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   // State register together with the bit counter, index and shifter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (!rx_s_q) begin
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (cnt_q == c_CNT_HALF) begin
               cnt_d = '0;
               idx_d = '0;
               // Line back high at mid start bit: treat as a glitch
               state_d = rx_s_q ? ST_IDLE : ST_DATA;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_DATA: begin
            if (cnt_q == c_CNT_LAST) begin
               cnt_d   = '0;
               // LSB arrives first, so shift in from the top
               shift_d = {rx_s_q, shift_q[7:1]};
               if (idx_q == 3'd7) begin
                  state_d = ST_STOP;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_STOP: begin
            if (cnt_q == c_CNT_LAST) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs decoded at the stop-bit sample point
   always_comb begin
      w_push      = 1'b0;
      w_frame_err = 1'b0;
      if ((state_q == ST_STOP) && (cnt_q == c_CNT_LAST)) begin
         w_push      = rx_s_q;
         w_frame_err = !rx_s_q;
      end
   end

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (w_push),
      .pop_i      (r_enable),
      .wdata_i    (shift_q),
      .rdata_o    (r_data),
      .empty_o    (w_empty),
      .overflow_o (overflow)
   );

   assign r_ready   = !w_empty;
   assign frame_err = w_frame_err;

endmodule
`default_nettype wire
